regfile_scoreboard: RTL and testbench

- Parametrised integer register file for the five-stage RISC-V core, successor to the fixed 32x32 two-read-port file.
- Width, depth and read-port count are configurable; x0 is hardwired to zero; all registers clear on reset.
- Adds a per-register busy scoreboard: set when the decode stage issues an instruction with a destination, cleared at writeback.
- Decode uses the scoreboard for hazard stalls; writeback drives the write port.

---
 rtl/regfile_scoreboard.sv | 88 ++++++++
 tb/tb_regfile_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with per-register busy scoreboard.
// x0 reads as zero; read ports are combinational; one write port driven by writeback.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
// of data and busy clear on each read port.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] addr_rs,
    output logic [NUM_RD*XLEN-1:0]   data_rs,
    output logic [NUM_RD-1:0]        busy_rs,
    input  logic [ADDR_W-1:0]        addr_rd,
    input  logic [XLEN-1:0]          data_rd,
    input  logic                     write_enable,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W-1:0]   w_addr;

    // Register storage: x0 is never written so it holds its reset value of zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < NUM_REGS; n++) begin
                r_regs[n] <= '0;
            end
        end else begin
            for (int unsigned n = 1; n < NUM_REGS; n++) begin
                if (write_enable && (addr_rd == ADDR_W'(n))) begin
                    r_regs[n] <= data_rd;
                end
            end
        end
    end

    // Scoreboard: issue sets, writeback clears, a same-edge issue wins over the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int unsigned n = 1; n < NUM_REGS; n++) begin
                if (issue_valid && (issue_rd == ADDR_W'(n))) begin
                    r_busy[n] <= 1'b1;
                end else if (write_enable && (addr_rd == ADDR_W'(n))) begin
                    r_busy[n] <= 1'b0;
                end
            end
        end
    end

    // Read ports: x0 and out-of-range addresses fall through to zero
    always_comb begin
        data_rs = '0;
        busy_rs = '0;
        w_addr  = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_addr = addr_rs[i*ADDR_W +: ADDR_W];
            for (int unsigned n = 1; n < NUM_REGS; n++) begin
                if (w_addr == ADDR_W'(n)) begin
                    data_rs[i*XLEN +: XLEN] = r_regs[n];
                    busy_rs[i]              = r_busy[n];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (write_enable && (addr_rd != '0) && (32'(addr_rd) < NUM_REGS) &&
                (w_addr == addr_rd)) begin
                data_rs[i*XLEN +: XLEN] = data_rd;
                busy_rs[i]              = issue_valid && (issue_rd == addr_rd);
            end
`endif
            if (reset) begin
                data_rs[i*XLEN +: XLEN] = '0;
                busy_rs[i]              = 1'b0;
            end
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NRD    = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_VEC  = 2;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic                  clock;
    logic                  reset;
    logic [NRD*AW-1:0]     addr_rs;
    logic [NRD*XLEN-1:0]   data_rs;
    logic [NRD-1:0]        busy_rs;
    logic [AW-1:0]         addr_rd;
    logic [XLEN-1:0]       data_rd;
    logic                  write_enable;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic [NREGS-1:0]      busy_vec;

    exp_t q[$];
    int   checks;
    int   errors;

    regfile_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NREGS), .ADDR_W(AW), .NUM_RD(NRD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .addr_rs(addr_rs),
        .data_rs(data_rs),
        .busy_rs(busy_rs),
        .addr_rd(addr_rd),
        .data_rd(data_rd),
        .write_enable(write_enable),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .busy_vec(busy_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rs(input int a1, input int a0);
        addr_rs = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        write_enable = 1'b0;
        issue_valid  = 1'b0;
        addr_rd      = '0;
        data_rd      = '0;
        issue_rd     = '0;
    endtask

    task automatic exp_push(input int kind, input int port, input logic [31:0] val,
                            input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: the DUT output is valid mid-cycle, so every queued expectation is
    // consumed at the falling edge of the cycle in which it was issued
    always @(negedge clock) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_DATA:  act = data_rs[e.port*XLEN +: XLEN];
                K_BUSY:  act = {31'd0, busy_rs[e.port]};
                default: act = busy_vec;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        addr_rs = '0;
        idle();
        step();
        step();
        reset = 1'b0;

        // Fill x1..x31 and mark each busy on the same edge (set beats clear)
        for (int n = 1; n < 32; n++) begin
            step();
            write_enable = 1'b1;
            addr_rd      = AW'(n);
            data_rd      = 32'(n) * 32'h0101_0101;
            issue_valid  = 1'b1;
            issue_rd     = AW'(n);
        end
        step();
        idle();
        set_rs(31, 5);
        exp_push(K_VEC, 0, 32'hFFFF_FFFE, "fill_busy_vec");
        exp_push(K_DATA, 0, 32'h0505_0505, "fill_x5");
        exp_push(K_DATA, 1, 32'h1F1F_1F1F, "fill_x31");

        // Asynchronous reset between edges clears everything immediately
        step();
        reset = 1'b1;
        exp_push(K_VEC, 0, 32'h0, "rst_busy_vec");
        exp_push(K_DATA, 0, 32'h0, "rst_x5");
        exp_push(K_BUSY, 1, 32'h0, "rst_busy_x31");
        step();
        reset = 1'b0;

        // Every register reads zero after reset
        for (int k = 0; k < 16; k++) begin
            step();
            set_rs(2*k + 1, 2*k);
            exp_push(K_DATA, 0, 32'h0, "post_rst_even");
            exp_push(K_DATA, 1, 32'h0, "post_rst_odd");
            exp_push(K_VEC, 0, 32'h0, "post_rst_vec");
        end

        // Write x5, read on both ports the next cycle
        step();
        set_rs(0, 0);
        write_enable = 1'b1;
        addr_rd      = AW'(5);
        data_rd      = 32'hDEAD_BEEF;
        step();
        idle();
        set_rs(5, 5);
        exp_push(K_DATA, 0, 32'hDEAD_BEEF, "x5_port0");
        exp_push(K_DATA, 1, 32'hDEAD_BEEF, "x5_port1");

        // Writes to x0 are dropped
        step();
        set_rs(0, 0);
        write_enable = 1'b1;
        addr_rd      = AW'(0);
        data_rd      = 32'h1234_5678;
        exp_push(K_DATA, 0, 32'h0, "x0_same_cycle");
        step();
        idle();
        exp_push(K_DATA, 0, 32'h0, "x0_after_write");
        exp_push(K_DATA, 1, 32'h0, "x0_after_write_p1");

        // Issue x7: busy is registered, visible only after the edge
        step();
        set_rs(7, 7);
        issue_valid = 1'b1;
        issue_rd    = AW'(7);
        exp_push(K_BUSY, 0, 32'h0, "x7_busy_same_cycle");
        step();
        idle();
        exp_push(K_VEC, 0, 32'h0000_0080, "x7_busy_vec");
        exp_push(K_BUSY, 0, 32'h1, "x7_busy_p0");
        exp_push(K_BUSY, 1, 32'h1, "x7_busy_p1");

        // Writeback x7 clears busy
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(7);
        data_rd      = 32'h0000_0001;
`ifdef REGFILE_BYPASS_EN
        exp_push(K_DATA, 0, 32'h0000_0001, "x7_wb_data_fwd");
        exp_push(K_BUSY, 0, 32'h0, "x7_wb_busy_fwd");
`else
        exp_push(K_DATA, 0, 32'h0, "x7_wb_data_old");
        exp_push(K_BUSY, 0, 32'h1, "x7_wb_busy_old");
`endif
        step();
        idle();
        exp_push(K_VEC, 0, 32'h0, "x7_cleared_vec");
        exp_push(K_DATA, 0, 32'h0000_0001, "x7_readback");
        exp_push(K_BUSY, 1, 32'h0, "x7_cleared_p1");

        // Busy x9, then issue and writeback x9 on the same edge: busy stays set
        step();
        set_rs(9, 9);
        issue_valid = 1'b1;
        issue_rd    = AW'(9);
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(9);
        data_rd      = 32'hAAAA_5555;
        exp_push(K_VEC, 0, 32'h0000_0200, "x9_busy_before");
        exp_push(K_BUSY, 1, 32'h1, "x9_busy_p1_same");
`ifdef REGFILE_BYPASS_EN
        exp_push(K_DATA, 1, 32'hAAAA_5555, "x9_data_fwd");
`else
        exp_push(K_DATA, 1, 32'h0, "x9_data_old");
`endif
        step();
        idle();
        exp_push(K_VEC, 0, 32'h0000_0200, "x9_busy_kept");
        exp_push(K_DATA, 0, 32'hAAAA_5555, "x9_updated");

        // Clear x9, then issue to x0 which must never go busy
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(9);
        data_rd      = 32'hAAAA_5555;
        step();
        idle();
        issue_valid = 1'b1;
        issue_rd    = AW'(0);
        exp_push(K_VEC, 0, 32'h0, "x9_cleared");
        step();
        idle();
        set_rs(0, 0);
        exp_push(K_VEC, 0, 32'h0, "x0_issue_vec");
        exp_push(K_BUSY, 0, 32'h0, "x0_issue_busy");

        // Write x3, then overwrite while reading it on port 1
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(3);
        data_rd      = 32'h1111_1111;
        step();
        set_rs(3, 0);
        data_rd      = 32'hCAFE_F00D;
`ifdef REGFILE_BYPASS_EN
        exp_push(K_DATA, 1, 32'hCAFE_F00D, "x3_fwd");
`else
        exp_push(K_DATA, 1, 32'h1111_1111, "x3_old");
`endif
        exp_push(K_DATA, 0, 32'h0, "x3_p0_x0");
        step();
        idle();
        exp_push(K_DATA, 1, 32'hCAFE_F00D, "x3_next");

        // Async reset mid-operation with x4 busy and holding 0xFF
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(4);
        data_rd      = 32'h0000_00FF;
        step();
        idle();
        issue_valid = 1'b1;
        issue_rd    = AW'(4);
        step();
        idle();
        set_rs(4, 4);
        exp_push(K_VEC, 0, 32'h0000_0010, "x4_busy_pre");
        exp_push(K_DATA, 0, 32'h0000_00FF, "x4_data_pre");
        step();
        reset = 1'b1;
        exp_push(K_VEC, 0, 32'h0, "x4_rst_vec");
        exp_push(K_DATA, 0, 32'h0, "x4_rst_data");
        exp_push(K_BUSY, 1, 32'h0, "x4_rst_busy");
        // Reset held across an edge overrides a write and an issue
        step();
        write_enable = 1'b1;
        addr_rd      = AW'(4);
        data_rd      = 32'h0000_0055;
        issue_valid  = 1'b1;
        issue_rd     = AW'(4);
        exp_push(K_DATA, 1, 32'h0, "rst_hold_data");
        exp_push(K_VEC, 0, 32'h0, "rst_hold_vec");
        step();
        reset = 1'b0;
        idle();
        exp_push(K_DATA, 0, 32'h0, "rst_override_data");
        exp_push(K_VEC, 0, 32'h0, "rst_override_vec");

        // Let the monitor drain the queue, bounded
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            @(posedge clock);
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
